// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Memory-stage data-access controller. Turns the M-stage load/store controls
// into a single sram-like request toward the AXI bridge and waits for the
// bridge to complete it. While the access is outstanding it holds d_stall so
// the pipeline (and therefore every M-stage input) stays frozen. Load data is
// captured raw and then lane-selected and extended with the current M-stage
// controls.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   memtoregM            M-stage instruction is a load
//   memwriteM[3:0]       nonzero: M-stage instruction is a store
//   data_lengthM[1:0]    00 byte, 01 half, 10/11 word
//   ls_extend_signedM    load sign-extends (1) or zero-extends (0)
//   aluoutM[31:0]        byte address
//   writedataM[31:0]     store source register value
//   mips_stall           global pipeline freeze (includes d_stall)
//   d_stall              access in M not yet complete
//   readdataM[31:0]      extended load result, valid when d_stall = 0
//   data_sram_req        request valid
//   data_sram_wr         1 for store
//   data_sram_size[1:0]  0 byte, 1 half, 2 word
//   data_sram_addr[31:0] request address (aluoutM)
//   data_sram_wdata      lane-replicated store data
//   data_sram_addr_ok    request accepted this cycle
//   data_sram_data_ok    data returned / write done this cycle
//   data_sram_rdata      raw read word
// ---------------------------------------------------------------------------
module dmem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        memtoregM,
    input  logic [3:0]  memwriteM,
    input  logic [1:0]  data_lengthM,
    input  logic        ls_extend_signedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        mips_stall,
    output logic        d_stall,
    output logic [31:0] readdataM,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_store;
    logic        access;

    assign is_store = |memwriteM;
    assign access   = memtoregM | is_store;

    // -----------------------------------------------------------------------
    // Next state and raw read-data capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (access && data_sram_addr_ok) begin
                    if (data_sram_data_ok) begin
                        // Accepted and completed in the same cycle.
                        state_d = ST_DONE;
                        rdata_d = data_sram_rdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    state_d = ST_DONE;
                    rdata_d = data_sram_rdata;
                end
            end
            ST_DONE: begin
                // The instruction leaves M on this edge only if nothing else
                // freezes the pipeline; until then DONE blocks a re-issue.
                if (!mips_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Request side. All of these depend only on frozen M-stage inputs plus
    // the state, so they hold steady until addr_ok.
    // -----------------------------------------------------------------------
    assign data_sram_req  = access && (state_q == ST_IDLE);
    assign data_sram_wr   = is_store;
    assign data_sram_addr = aluoutM;
    assign d_stall        = access && (state_q != ST_DONE);

    always_comb begin
        data_sram_size  = 2'd2;
        data_sram_wdata = writedataM;
        case (data_lengthM)
            2'b00: begin
                data_sram_size  = 2'd0;
                data_sram_wdata = {4{writedataM[7:0]}};
            end
            2'b01: begin
                data_sram_size  = 2'd1;
                data_sram_wdata = {2{writedataM[15:0]}};
            end
            default: begin
                data_sram_size  = 2'd2;
                data_sram_wdata = writedataM;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Load lane select and extension from the captured raw word
    // -----------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata_q[7:0];
        case (aluoutM[1:0])
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
            default: ld_byte = rdata_q[7:0];
        endcase

        ld_half = aluoutM[1] ? rdata_q[31:16] : rdata_q[15:0];

        readdataM = rdata_q;
        case (data_lengthM)
            2'b00: readdataM = {{24{ls_extend_signedM & ld_byte[7]}}, ld_byte};
            2'b01: readdataM = {{16{ls_extend_signedM & ld_half[15]}}, ld_half};
            default: readdataM = rdata_q;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl. The bench plays the AXI bridge
// (addr_ok / data_ok / rdata) and the rest of the pipeline (mips_stall is
// d_stall OR an extra i_stall). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoregM;
    logic [3:0]  memwriteM;
    logic [1:0]  data_lengthM;
    logic        ls_extend_signedM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        mips_stall;
    logic        i_stall;
    logic        d_stall;
    logic [31:0] readdataM;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;

    always #5 clk = ~clk;

    assign mips_stall = d_stall | i_stall;

    dmem_access_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .memtoregM         (memtoregM),
        .memwriteM         (memwriteM),
        .data_lengthM      (data_lengthM),
        .ls_extend_signedM (ls_extend_signedM),
        .aluoutM           (aluoutM),
        .writedataM        (writedataM),
        .mips_stall        (mips_stall),
        .d_stall           (d_stall),
        .readdataM         (readdataM),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    // Accepted request handshakes seen by the bridge.
    always @(posedge clk) begin
        if (data_sram_req && data_sram_addr_ok) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic [3:0] we, input logic [1:0] len,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        memtoregM         = ld;
        memwriteM         = we;
        data_lengthM      = len;
        ls_extend_signedM = sgn;
        aluoutM           = addr;
        writedataM        = wd;
    endtask

    // Runs one bridge transaction for the op currently in M. Entered just
    // after a rising edge; returns at the falling edge of the DONE cycle.
    task automatic run_access(input string nm, input int hold_off, input bit same,
                              input logic [31:0] rd, input logic [31:0] exp_addr);
        int hs0;
        hs0 = hs_cnt;
        for (int i = 0; i < hold_off; i++) begin
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b0;
            @(negedge clk);
            check({nm, "_hold_req"},   32'(data_sram_req), 32'd1);
            check({nm, "_hold_addr"},  data_sram_addr, exp_addr);
            check({nm, "_hold_stall"}, 32'(d_stall), 32'd1);
            step();
        end
        data_sram_addr_ok = 1'b1;
        data_sram_data_ok = same;
        data_sram_rdata   = rd;
        @(negedge clk);
        check({nm, "_c0_req"},   32'(data_sram_req), 32'd1);
        check({nm, "_c0_stall"}, 32'(d_stall), 32'd1);
        check({nm, "_c0_addr"},  data_sram_addr, exp_addr);
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        if (!same) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rd;
            @(negedge clk);
            check({nm, "_wait_req"},   32'(data_sram_req), 32'd0);
            check({nm, "_wait_stall"}, 32'(d_stall), 32'd1);
            step();
            data_sram_data_ok = 1'b0;
        end
        @(negedge clk);
        check({nm, "_done_stall"}, 32'(d_stall), 32'd0);
        check({nm, "_done_req"},   32'(data_sram_req), 32'd0);
        check({nm, "_handshakes"}, 32'(hs_cnt - hs0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_stall           = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        rst               = 1'b1;

        // Reset held with a pending lw in M.
        set_op(1'b1, 4'h0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        step();
        @(negedge clk);
        check("rst_readdata", readdataM, 32'h0);
        check("rst_stall",    32'(d_stall), 32'd1);
        check("rst_req",      32'(data_sram_req), 32'd1);
        step();
        rst = 1'b0;

        // lw 0x100: addr_ok c0, data_ok c1, DONE c2.
        check("lw_wr",   32'(data_sram_wr), 32'd0);
        check("lw_size", 32'(data_sram_size), 32'd2);
        run_access("lw", 0, 1'b0, 32'h8899_AABB, 32'h0000_0100);
        check("lw_data", readdataM, 32'h8899_AABB);

        // Extra stall after DONE: no re-issue, data held, stray data_ok ignored.
        i_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            data_sram_data_ok = (i == 1);
            data_sram_rdata   = 32'hDEAD_BEEF;
            @(negedge clk);
            check("istall_req",   32'(data_sram_req), 32'd0);
            check("istall_stall", 32'(d_stall), 32'd0);
            check("istall_data",  readdataM, 32'h8899_AABB);
        end
        data_sram_data_ok = 1'b0;
        i_stall = 1'b0;
        check("istall_hs", 32'(hs_cnt), 32'd1);
        step();

        // lb signed at 0x103.
        set_op(1'b1, 4'h0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        run_access("lb", 0, 1'b0, 32'h8011_2233, 32'h0000_0103);
        check("lb_data", readdataM, 32'hFFFF_FF80);
        step();

        // lhu at 0x102.
        set_op(1'b1, 4'h0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
        run_access("lhu", 0, 1'b0, 32'h8011_2233, 32'h0000_0102);
        check("lhu_data", readdataM, 32'h0000_8011);
        step();

        // sb at 0x101 with addr_ok held off for 3 cycles.
        set_op(1'b0, 4'h2, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5678);
        #1;
        check("sb_wr",    32'(data_sram_wr), 32'd1);
        check("sb_size",  32'(data_sram_size), 32'd0);
        check("sb_wdata", data_sram_wdata, 32'h7878_7878);
        run_access("sb", 3, 1'b0, 32'h0000_0000, 32'h0000_0101);
        step();

        // lw at 0x200 with addr_ok and data_ok together.
        set_op(1'b1, 4'h0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        run_access("lwsame", 0, 1'b1, 32'h0123_4567, 32'h0000_0200);
        check("lwsame_data", readdataM, 32'h0123_4567);
        step();

        // Back-to-back sw (length 11 means word): request on the first cycle.
        set_op(1'b0, 4'hF, 2'b11, 1'b0, 32'h0000_0204, 32'hCAFE_1234);
        #1;
        check("sw_b2b_req", 32'(data_sram_req), 32'd1);
        check("sw_size",    32'(data_sram_size), 32'd2);
        check("sw_wdata",   data_sram_wdata, 32'hCAFE_1234);
        run_access("sw", 0, 1'b1, 32'h0123_4567, 32'h0000_0204);
        step();

        // sh: halfword replicated.
        set_op(1'b0, 4'h3, 2'b01, 1'b0, 32'h0000_0206, 32'hAAAA_BEEF);
        #1;
        check("sh_size",  32'(data_sram_size), 32'd1);
        check("sh_wdata", data_sram_wdata, 32'hBEEF_BEEF);
        run_access("sh", 1, 1'b0, 32'h0123_4567, 32'h0000_0208 - 32'd2);
        step();

        // Non-memory instruction: no request, no stall, stray data_ok ignored.
        set_op(1'b0, 4'h0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        @(negedge clk);
        check("nomem_req",   32'(data_sram_req), 32'd0);
        check("nomem_stall", 32'(d_stall), 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("nomem_data_held", readdataM, 32'h0123_4567);
        check("nomem_stall2",    32'(d_stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-access controller for the pipelined MIPS core. It consumes the M-stage memory controls (`memtoregM`, `memwriteM`, `data_lengthM`, `ls_extend_signedM`) with the ALU address and store data. It drives an sram-like request/handshake port toward the AXI bridge and returns the extended load data. It raises `d_stall`, which is OR-ed into `mips_stall` to freeze the pipeline while an access is outstanding.

## Interface
Parameters: none.
- `clk` in 1: core clock
- `rst` in 1: synchronous, active-high reset
- `memtoregM` in 1: M-stage instruction is a load
- `memwriteM` in 4: nonzero means the M-stage instruction is a store
- `data_lengthM` in 2: access width; 00 byte, 01 half, 10 word (11 treated as word)
- `ls_extend_signedM` in 1: load sign-extends (1) or zero-extends (0)
- `aluoutM` in 32: byte address
- `writedataM` in 32: store source register value
- `mips_stall` in 1: global pipeline freeze, this block's `d_stall` included
- `d_stall` out 1: access in M not yet complete
- `readdataM` out 32: extended load result, valid when `d_stall`=0
- `data_sram_req` out 1: request valid
- `data_sram_wr` out 1: 1 for store
- `data_sram_size` out 2: 0 byte, 1 half, 2 word
- `data_sram_addr` out 32: equals `aluoutM`
- `data_sram_wdata` out 32: lane-replicated store data
- `data_sram_addr_ok` in 1: request accepted this cycle
- `data_sram_data_ok` in 1: data returned or write done this cycle
- `data_sram_rdata` in 32: raw read word

## Operation
- `access` = `memtoregM` | (|`memwriteM`). `data_sram_wr` = |`memwriteM`.
- States:
  - IDLE: if `access`, drive `req`=1 combinationally.
    - `addr_ok`&`data_ok` → DONE.
    - `addr_ok` only → WAIT.
    - Otherwise stay in IDLE with `req` held.
  - WAIT: `req`=0. On `data_ok`, capture `rdata` and go to DONE.
  - DONE: `req`=0. When `mips_stall`=0, the pipeline advances at this edge → IDLE.
- `d_stall` = `access` & (state≠DONE).
- The finished flag (DONE) prevents re-issuing an instruction that stays in M while other stall sources (e.g. `i_stall`) hold the pipeline.
- Store data:
  - byte → {4{`writedataM`[7:0]}}
  - half → {2{`writedataM`[15:0]}}
  - word → unchanged
  - Byte strobes are derived downstream from size and `addr[1:0]`.
- Load extraction from the captured word:
  - byte lane = `addr[1:0]`
  - half lane = `addr[1]`
  - Extend to 32 bits per `ls_extend_signedM`.
  - Computed from the registered raw word and current M controls, which are stable because the pipeline is frozen until DONE.
- Alignment is not checked here; the exception logic upstream suppresses misaligned accesses before M.
- Request outputs are functions of the M-stage inputs, which are frozen while `d_stall`=1. They are therefore stable until `addr_ok`.

## Timing
- Reset: state IDLE, raw-data register 0, `readdataM`=0.
  - `req`=0 unless `access` is present in IDLE.
  - `d_stall`=`access`.
  - Reset mid-access abandons the transaction; the bridge is reset by the same `rst`.
- Best case, with the access entering M at cycle 0:
  - `addr_ok` at c0, `data_ok` at c1 → DONE at c2.
  - `d_stall` low at c2; `readdataM` valid at c2.
  - The pipeline advances at the end of c2 if no other stall.
- `addr_ok` and `data_ok` in the same cycle (c0): DONE at c1.
- `data_ok` arriving while in IDLE or DONE is ignored.
- Back-to-back accesses: DONE→IDLE at the advancing edge. The next instruction's `req` is asserted in the following cycle with no bubble.
- Non-memory instruction in M: `req`=0, `d_stall`=0, state stays IDLE.

## Test plan
- Reset with a pending access: hold `rst` while `memtoregM`=1 → state IDLE, `readdataM`=0; after release `req`=1, `d_stall`=1.
- `lw` at 0x100, `addr_ok` at c0, `data_ok` at c1 with `rdata`=0x8899AABB → `d_stall` low at c2, `readdataM`=0x8899AABB, exactly one `req` handshake.
- `lb` signed at 0x103 with `rdata`=0x80112233 → 0xFFFFFF80; `lhu` at 0x102 with the same data → 0x00008011.
- `sb` of 0x12345678 at 0x101 → `wr`=1, `size`=0, `wdata`=0x78787878; `addr_ok` held off 3 cycles → `req` and `addr` stable throughout.
- `mips_stall` held 4 extra cycles after DONE (`i_stall`) → no second `req`; `d_stall` stays 0; `readdataM` stays constant.
- `addr_ok`&`data_ok` same cycle → DONE next cycle; then a back-to-back `sw` → new `req` on the cycle after the advance.
